// File: rtl/adder_arbiter_28b.sv
// adder_arbiter_28b
//
// Round-robin arbiter sharing one registered (WIDTH+1)-bit adder between four
// requesters. One requester is granted per cycle; its a + b + cin lands in a
// result register that is presented with the requester ID on a valid/ready
// result port. A pop and a new accept may happen on the same edge, so the
// block sustains one result per cycle while the consumer is ready.
//
// Optional feature: define ADDER_ARB_STATS_EN to add grant_cnt, four
// saturating 16-bit per-requester accept counters.
//
// Ports:
//   clk        rising-edge clock
//   rstn       asynchronous active-low reset
//   req_valid  per-requester operand valid
//   req_ready  per-requester accept strobe (one-hot or zero)
//   req_a      packed operand A, requester i at [i*WIDTH +: WIDTH]
//   req_b      packed operand B, same packing
//   req_cin    per-requester carry-in
//   res_valid  result register holds a result
//   res_ready  consumer takes the result
//   res_sum    a + b + cin of the granted request, full width
//   res_id     index of the requester that produced res_sum
//   grant_cnt  (ADDER_ARB_STATS_EN only) counter i at [i*16 +: 16]

module adder_arbiter_28b #(
  parameter int unsigned WIDTH = 28,
  parameter int unsigned N_REQ = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  input  logic [N_REQ-1:0]       req_cin,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [WIDTH:0]         res_sum,
  output logic [1:0]             res_id
`ifdef ADDER_ARB_STATS_EN
  ,
  output logic [N_REQ*16-1:0]    grant_cnt
`endif
);

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e     state_q;
  logic [1:0] rr_ptr_q;

  logic [1:0]     win;
  logic           win_found;
  logic           can_accept;
  logic           accept;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic [WIDTH:0]   sum_d;

  // Search from rr_ptr upward, wrapping; 2-bit index arithmetic gives the wrap.
  always_comb begin
    logic [1:0] idx;
    win       = '0;
    win_found = 1'b0;
    idx       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = rr_ptr_q + 2'(k);
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win       = idx;
      end
    end
  end

  // Free slot now, or the held result leaves on this same edge.
  assign can_accept = (state_q == StEmpty) || res_ready;

  always_comb begin
    req_ready = '0;
    if (rstn && win_found && can_accept) begin
      req_ready[win] = 1'b1;
    end
  end

  assign accept = |(req_valid & req_ready);

  assign a_sel = req_a[win*WIDTH +: WIDTH];
  assign b_sel = req_b[win*WIDTH +: WIDTH];
  assign sum_d = {1'b0, a_sel} + {1'b0, b_sel} + (WIDTH+1)'(req_cin[win]);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= StEmpty;
      res_sum  <= '0;
      res_id   <= '0;
      rr_ptr_q <= '0;
    end else begin
      if (accept) begin
        res_sum  <= sum_d;
        res_id   <= win;
        rr_ptr_q <= win + 2'd1;
        state_q  <= StFull;
      end else if ((state_q == StFull) && res_ready) begin
        // Popped with nothing new: sum/id keep their stale values.
        state_q <= StEmpty;
      end
    end
  end

  assign res_valid = (state_q == StFull);

`ifdef ADDER_ARB_STATS_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      grant_cnt <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (accept && (win == 2'(i)) && (grant_cnt[i*16 +: 16] != 16'hFFFF)) begin
          grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_adder_arbiter_28b.sv
// Self-checking bench for adder_arbiter_28b: directed scenarios plus
// randomized traffic compared against a cycle-level behavioural model.

module tb_adder_arbiter_28b;

  localparam int W = 28;

  logic            clk;
  logic            rstn;
  logic [3:0]      req_valid;
  logic [3:0]      req_ready;
  logic [4*W-1:0]  req_a;
  logic [4*W-1:0]  req_b;
  logic [3:0]      req_cin;
  logic            res_valid;
  logic            res_ready;
  logic [W:0]      res_sum;
  logic [1:0]      res_id;
`ifdef ADDER_ARB_STATS_EN
  logic [63:0]     grant_cnt;
`endif

  adder_arbiter_28b dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_id    (res_id)
`ifdef ADDER_ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Behavioural model state.
  bit          m_full;
  logic [W:0]  m_sum;
  int          m_id;
  int          m_ptr;
  int          m_acc;
  int          m_cnt[4];

  task automatic model_reset();
    m_full = 0;
    m_sum  = '0;
    m_id   = 0;
    m_ptr  = 0;
    m_acc  = -1;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
  endtask

  function automatic int model_win();
    for (int k = 0; k < 4; k++) begin
      if (req_valid[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_cin[i]      = cin;
  endtask

  task automatic new_ops(input int i);
    logic [31:0] ra;
    logic [31:0] rb;
    ra = $urandom;
    rb = $urandom;
    if ($urandom_range(7, 0) == 0) ra = 32'h0FFF_FFFF;
    if ($urandom_range(7, 0) == 0) rb = 32'h0FFF_FFFF;
    set_req(i, ra[W-1:0], rb[W-1:0], 1'($urandom_range(1, 0)));
  endtask

  // One clock: check outputs mid-cycle against the model, then advance it.
  // Returns #1 after the rising edge.
  task automatic cycle();
    int          w;
    logic [3:0]  er;
    longint      s;
    @(negedge clk);
    w  = model_win();
    er = '0;
    if (rstn && (w >= 0) && (!m_full || res_ready)) er[w] = 1'b1;
    check("req_ready", 64'(req_ready), 64'(er));
    check("res_valid", 64'(res_valid), 64'(m_full));
    check("res_sum", 64'(res_sum), 64'(m_sum));
    check("res_id", 64'(res_id), 64'(m_id));
`ifdef ADDER_ARB_STATS_EN
    for (int i = 0; i < 4; i++) check("grant_cnt", 64'(grant_cnt[i*16 +: 16]), 64'(m_cnt[i]));
`endif
    @(posedge clk);
    m_acc = -1;
    if (!rstn) begin
      model_reset();
    end else if (er != 0) begin
      s = longint'(req_a[w*W +: W]) + longint'(req_b[w*W +: W]) + longint'(req_cin[w]);
      m_sum  = s[W:0];
      m_id   = w;
      m_ptr  = (w + 1) % 4;
      m_full = 1;
      m_acc  = w;
      if (m_cnt[w] < 65535) m_cnt[w]++;
    end else if (m_full && res_ready) begin
      m_full = 0;
    end
    #1;
  endtask

  logic [W:0] held_sum;
  logic [1:0] held_id;

  initial begin
    rstn      = 1'b0;
    req_valid = 4'hF;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
    res_ready = 1'b1;
    model_reset();

    // Reset held with all requesters valid.
    repeat (3) cycle();
    req_valid = '0;
    rstn      = 1'b1;

    // Single request, carry out of bit 27.
    set_req(2, 28'hFFFFFFF, 28'h0000001, 1'b0);
    req_valid = 4'b0100;
    cycle();
    req_valid = '0;
    check("single_valid", 64'(res_valid), 64'd1);
    check("single_sum", 64'(res_sum), 64'h1000_0000);
    check("single_id", 64'(res_id), 64'd2);
    cycle();
    check("single_idle_valid", 64'(res_valid), 64'd0);

    // Round-robin from a fresh pointer.
    rstn = 1'b0;
    model_reset();
    cycle();
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, W'(i), W'(100), 1'b1);
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("rr_valid", 64'(res_valid), 64'd1);
      check("rr_id", 64'(res_id), 64'(k % 4));
      check("rr_sum", 64'(res_sum), 64'(101 + k % 4));
    end

    // Backpressure with requesters 1 and 3; pointer now at 1.
    req_valid = 4'b1010;
    cycle();
    check("bp_first_id", 64'(res_id), 64'd1);
    held_sum  = res_sum;
    held_id   = res_id;
    res_ready = 1'b0;
    repeat (5) begin
      cycle();
      check("bp_hold_sum", 64'(res_sum), 64'(held_sum));
      check("bp_hold_id", 64'(res_id), 64'(held_id));
      check("bp_ready0", 64'(req_ready), 64'd0);
    end
    res_ready = 1'b1;
    cycle();
    check("bp_next_valid", 64'(res_valid), 64'd1);
    check("bp_next_id", 64'(res_id), 64'd3);
    check("bp_next_sum", 64'(res_sum), 64'd104);

    // Reset while FULL and stalled.
    res_ready = 1'b0;
    cycle();
    check("mid_full", 64'(res_valid), 64'd1);
    rstn = 1'b0;
    model_reset();
    #1;
    check("mid_rst_valid", 64'(res_valid), 64'd0);
    check("mid_rst_sum", 64'(res_sum), 64'd0);
    check("mid_rst_ready", 64'(req_ready), 64'd0);
    repeat (2) cycle();
    rstn      = 1'b1;
    req_valid = 4'hF;
    res_ready = 1'b1;
    cycle();
    check("mid_first_id", 64'(res_id), 64'd0);

    // Randomized traffic; requesters hold operands until accepted.
    req_valid = '0;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (req_valid[i]) begin
          if (m_acc == i) begin
            if ($urandom_range(1, 0) == 1) req_valid[i] = 1'b0;
            else new_ops(i);
          end
        end else if ($urandom_range(1, 0) == 1) begin
          new_ops(i);
          req_valid[i] = 1'b1;
        end
      end
      res_ready = ($urandom_range(3, 0) != 0);
      cycle();
    end

`ifdef ADDER_ARB_STATS_EN
    // Saturation of requester 1's counter.
    rstn = 1'b0;
    model_reset();
    cycle();
    rstn      = 1'b1;
    req_valid = 4'b0010;
    res_ready = 1'b1;
    repeat (70000) @(posedge clk);
    #1;
    check("cnt0", 64'(grant_cnt[15:0]), 64'd0);
    check("cnt1_sat", 64'(grant_cnt[31:16]), 64'hFFFF);
    check("cnt2", 64'(grant_cnt[47:32]), 64'd0);
    check("cnt3", 64'(grant_cnt[63:48]), 64'd0);
    rstn = 1'b0;
    #1;
    check("cnt_rst", 64'(grant_cnt), 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/adder_arbiter_28b.md
# adder_arbiter_28b

Round-robin arbiter that shares one registered 28-bit adder between four requesters. Each requester presents operands with a valid/ready handshake. The block grants one requester per cycle, computes the 29-bit sum into an output register, and presents it with the winning requester's ID on a valid/ready result port. It sits between the operand-producing blocks and a single adder instance, in place of one adder per requester.

## Interface
- `WIDTH`, 28: operand width; sum is `WIDTH+1` bits.
- `N_REQ`, 4: number of requesters; fixed at 4 (ID is 2 bits).
- `clk` in 1: single clock, rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `req_valid` in 4: bit i = requester i has operands.
- `req_ready` out 4: bit i = requester i accepted this cycle (one-hot or zero).
- `req_a` in 4*WIDTH: operand A; requester i at bits `[i*WIDTH +: WIDTH]`.
- `req_b` in 4*WIDTH: operand B; same packing as `req_a`.
- `req_cin` in 4: carry-in, bit i for requester i.
- `res_valid` out 1: result register holds a result.
- `res_ready` in 1: consumer takes the result.
- `res_sum` out WIDTH+1: `a + b + cin` of the granted request.
- `res_id` out 2: index of the requester that produced `res_sum`.
- `grant_cnt` out 4*16 (only with `ADDER_ARB_STATS_EN`): per-requester accept counters.

## Operation
- States:
  - EMPTY: `res_valid`=0.
  - FULL: `res_valid`=1.
- `can_accept` = EMPTY, or (FULL and `res_ready`).
- Grant:
  - Search `req_valid` starting at `rr_ptr`, ascending, wrapping 3→0.
  - The first set bit wins.
  - `req_ready[win]` = `can_accept`; all other bits are 0.
  - `req_ready` is combinational from `req_valid`, `rr_ptr`, state and `res_ready`.
- Accept = `req_valid[win]` & `req_ready[win]`. On accept:
  - `res_sum` <= `a[win] + b[win] + cin[win]`, full 29-bit result with no truncation.
  - `res_id` <= win.
  - `rr_ptr` <= (win+1) mod 4.
  - Next state is FULL.
- FULL with `res_ready`=1 and no accept: next state is EMPTY; `res_sum` and `res_id` hold their stale values.
- FULL with `res_ready`=0: everything holds and `req_ready` is 0. Operands are not sampled.
- Simultaneous pop and accept in FULL: the new result replaces the old one in the same edge and the state stays FULL. This gives one result per cycle at full throughput.
- `rr_ptr` changes only on accept. Requesters idle for the whole cycle do not move it.
- Requester contract: a requester must hold `req_valid`, `req_a`, `req_b` and `req_cin` stable until its `req_ready` is seen. The block does not check this.
- Consumer contract: `res_sum` and `res_id` are stable while `res_valid`=1 and `res_ready`=0.

## Timing
- Reset values (asynchronous, immediate on `rstn`=0):
  - `res_valid`=0, `res_sum`=0, `res_id`=0.
  - `rr_ptr`=0, state EMPTY.
  - `grant_cnt`=0.
- With `rstn` low, `req_ready`=0.
- First accept is possible on the first rising edge after `rstn` deasserts.
- Latency: accept at edge t gives `res_valid`=1 with the sum visible after edge t (one cycle).
- Throughput: one accept per cycle while `res_ready`=1.
- Reset mid-operation: a held result is discarded, an in-flight accept is lost, and `rr_ptr` returns to 0.
- Fairness: with all four requesters valid continuously and `res_ready`=1, the grant sequence is 0,1,2,3,0,... Each requester waits at most 3 accepts.

## Configuration
- `ADDER_ARB_STATS_EN` defined:
  - Adds the `grant_cnt` port: four 16-bit counters, requester i at `[i*16 +: 16]`.
  - Counter i increments on each accept of requester i.
  - Counters saturate at 16'hFFFF (no wrap) and reset to 0.
- Not defined: the port and counters are absent; all other behaviour is identical.

## Test plan
- Reset: hold `rstn`=0 for 3 cycles with all `req_valid`=1 → `req_ready`=0, `res_valid`=0, `res_sum`=0, `res_id`=0 throughout.
- Single request:
  - Stimulus: req 2 with a=28'hFFFFFFF, b=28'h0000001, cin=0; `res_ready`=1.
  - Required response: one cycle later `res_valid`=1, `res_sum`=29'h10000000, `res_id`=2. The next idle cycle gives `res_valid`=0.
- Round-robin:
  - Stimulus: all four valid continuously, requester i with a=i, b=100, cin=1; `res_ready`=1.
  - Required response: `res_id` sequence 0,1,2,3,0; `res_sum` sequence 101,102,103,104,101; `res_valid` high every cycle.
- Backpressure:
  - Stimulus: `res_ready`=0 for 5 cycles after the first result, with requesters 1 and 3 valid.
  - Required response: `res_sum` and `res_id` stable, `req_ready`=0. On `res_ready`=1, the pending result pops and the next grant goes the same cycle (round-robin order from `rr_ptr`).
- Reset mid-stream: assert `rstn`=0 while FULL with `res_ready`=0 → `res_valid` drops immediately. After release with all four valid, the first grant is requester 0.
- Stats (with `ADDER_ARB_STATS_EN`):
  - Stimulus: 70000 back-to-back accepts of requester 1 only.
  - Required response: `grant_cnt[1]`=16'hFFFF and the other counters are 0. After reset, all counters are 0.
